// File: rtl/scan_sequencer_pkg.sv
// Shared types and constants for the scan sequencer.
// State encoding, decoder-off level and default dwell width.
package scan_sequencer_pkg;

   localparam int   DWELL_W_DEF = 8;
   localparam logic G_OFF       = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACTIVE,
      S_GAP,
      S_DONE
   } state_t;

endpackage

// File: rtl/scan_next_sel.sv
// Channel selector: next higher unskipped channel, lowest unskipped
// channel, and a wrap flag when nothing higher remains.
module scan_next_sel
   import scan_sequencer_pkg::*;
(
   input  logic [2:0] ch,
   input  logic [7:0] mask,
   output logic [2:0] nxt,
   output logic [2:0] low,
   output logic       wrap,
   output logic       none
);

   logic [2:0] hi;

   always_comb begin
      low  = 3'd0;
      none = 1'b1;
      hi   = 3'd0;
      wrap = 1'b1;
      // descending scans leave the lowest qualifying index last
      for (int i = 7; i >= 0; i--) begin
         if (!mask[i]) begin
            low  = 3'(i);
            none = 1'b0;
         end
         if (!mask[i] && (i > int'(ch))) begin
            hi   = 3'(i);
            wrap = 1'b0;
         end
      end
      nxt = wrap ? low : hi;
   end

endmodule

// File: rtl/scan_sequencer.sv
// Channel scan sequencer driving an active-low 3-to-8 decoder with
// break-before-make gaps between channels.
module scan_sequencer
   import scan_sequencer_pkg::*;
#(
   parameter int DWELL_W = DWELL_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               cont,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [7:0]         skip_mask,
   output logic               G,
   output logic               A,
   output logic               B,
   output logic               C,
   output logic               busy,
   output logic               done
);

   state_t             state;
   logic               cont_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] cnt;
   logic [DWELL_W-1:0] load;
   logic [7:0]         mask_q;
   logic [7:0]         sel_mask;
   logic [2:0]         ch;
   logic [2:0]         nxt;
   logic [2:0]         low;
   logic               wrap;
   logic               none;

   assign ch = {C, B, A};

   // in IDLE the first channel comes from the mask being latched now
   assign sel_mask = (state == S_IDLE) ? skip_mask : mask_q;

   // cnt holds remaining cycles after the current one; dwell 0 acts as 1
   assign load = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

   scan_next_sel u_sel (
      .ch   (ch),
      .mask (sel_mask),
      .nxt  (nxt),
      .low  (low),
      .wrap (wrap),
      .none (none)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         G         <= G_OFF;
         {C, B, A} <= 3'b000;
         busy      <= 1'b0;
         done      <= 1'b0;
         cnt       <= '0;
         cont_q    <= 1'b0;
         dwell_q   <= '0;
         mask_q    <= '0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            state <= S_IDLE;
            G     <= G_OFF;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (start) begin
                     cont_q    <= cont;
                     dwell_q   <= dwell;
                     mask_q    <= skip_mask;
                     {C, B, A} <= low;
                     busy      <= 1'b1;
                     state     <= S_SETUP;
                  end
               end
               S_SETUP: begin
                  if (none) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     G     <= ~G_OFF;
                     cnt   <= load;
                     state <= S_ACTIVE;
                  end
               end
               S_ACTIVE: begin
                  if (cnt != '0) begin
                     cnt <= cnt - DWELL_W'(1);
                  end else begin
                     G <= G_OFF;
                     if (!wrap || cont_q) begin
                        {C, B, A} <= nxt;
                        state     <= S_GAP;
                     end else begin
                        done  <= 1'b1;
                        state <= S_DONE;
                     end
                  end
               end
               S_GAP: begin
                  G     <= ~G_OFF;
                  cnt   <= load;
                  state <= S_ACTIVE;
               end
               S_DONE: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: sweeps, skips, wrap, stop,
// dwell 0, all-skipped mask and asynchronous reset.
module tb_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       stop;
   logic       cont;
   logic [7:0] dwell;
   logic [7:0] skip_mask;
   logic       G, A, B, C, busy, done;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   scan_sequencer #(.DWELL_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .cont      (cont),
      .dwell     (dwell),
      .skip_mask (skip_mask),
      .G         (G),
      .A         (A),
      .B         (B),
      .C         (C),
      .busy      (busy),
      .done      (done)
   );

   function automatic logic [5:0] obs();
      return {busy, done, G, C, B, A};
   endfunction

   function automatic logic [5:0] ex(bit b, bit d, bit g, int ch);
      return {b, d, g, 3'(ch)};
   endfunction

   task automatic check(string tag, logic [5:0] got, logic [5:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got {busy,done,G,CBA}=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // accepting edge, then scramble inputs that must already be latched
   task automatic go(bit c, logic [7:0] d, logic [7:0] m);
      start     = 1'b1;
      cont      = c;
      dwell     = d;
      skip_mask = m;
      tick();
      start     = 1'b0;
      cont      = ~c;
      dwell     = 8'd7;
      skip_mask = ~m;
   endtask

   int chs[4] = '{0, 2, 4, 6};

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      stop      = 1'b0;
      cont      = 1'b0;
      dwell     = 8'd0;
      skip_mask = 8'd0;
      #1;
      check("reset", obs(), ex(0, 0, 1, 0));
      tick();
      tick();
      check("reset_hold", obs(), ex(0, 0, 1, 0));
      rst = 1'b0;

      // full single sweep, dwell 3
      go(0, 8'd3, 8'h00);
      check("t1 setup", obs(), ex(1, 0, 1, 0));
      for (int ch = 0; ch < 8; ch++) begin
         for (int k = 0; k < 3; k++) begin
            start = (ch == 2 && k == 0);
            tick();
            check($sformatf("t1 act ch%0d k%0d", ch, k), obs(), ex(1, 0, 0, ch));
         end
         start = 1'b0;
         if (ch < 7) begin
            tick();
            check($sformatf("t1 gap ch%0d", ch + 1), obs(), ex(1, 0, 1, ch + 1));
         end
      end
      tick();
      check("t1 done", obs(), ex(1, 1, 1, 7));
      tick();
      check("t1 idle", obs(), ex(0, 0, 1, 7));
      tick();
      check("t1 idle2", obs(), ex(0, 0, 1, 7));

      // continuous, odd channels skipped, two laps
      go(1, 8'd2, 8'hAA);
      check("t2 setup", obs(), ex(1, 0, 1, 0));
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("t2 act i%0d k%0d", i, k), obs(), ex(1, 0, 0, chs[i % 4]));
         end
         tick();
         check($sformatf("t2 gap i%0d", i), obs(), ex(1, 0, 1, chs[(i + 1) % 4]));
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("t2 stop", obs(), ex(0, 0, 1, 0));

      // continuous, stop on second active cycle of channel 5
      go(1, 8'd3, 8'h00);
      check("t3 setup", obs(), ex(1, 0, 1, 0));
      for (int ch = 0; ch < 5; ch++) begin
         for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t3 act ch%0d k%0d", ch, k), obs(), ex(1, 0, 0, ch));
         end
         tick();
         check($sformatf("t3 gap ch%0d", ch + 1), obs(), ex(1, 0, 1, ch + 1));
      end
      tick();
      check("t3 ch5 k0", obs(), ex(1, 0, 0, 5));
      tick();
      check("t3 ch5 k1", obs(), ex(1, 0, 0, 5));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("t3 stop", obs(), ex(0, 0, 1, 5));
      tick();
      check("t3 idle", obs(), ex(0, 0, 1, 5));

      // every channel skipped
      go(0, 8'd3, 8'hFF);
      check("t4 setup", obs(), ex(1, 0, 1, 0));
      tick();
      check("t4 done", obs(), ex(1, 1, 1, 0));
      tick();
      check("t4 idle", obs(), ex(0, 0, 1, 0));

      // dwell 0 behaves as one cycle
      go(0, 8'd0, 8'hFE);
      check("t5 setup", obs(), ex(1, 0, 1, 0));
      tick();
      check("t5 act", obs(), ex(1, 0, 0, 0));
      tick();
      check("t5 done", obs(), ex(1, 1, 1, 0));
      tick();
      check("t5 idle", obs(), ex(0, 0, 1, 0));

      // asynchronous reset mid-active
      go(1, 8'd5, 8'h0F);
      check("t6 setup", obs(), ex(1, 0, 1, 4));
      tick();
      check("t6 act", obs(), ex(1, 0, 0, 4));
      #2 rst = 1'b1;
      #1;
      check("t6 async rst", obs(), ex(0, 0, 1, 0));
      tick();
      rst   = 1'b0;
      start = 1'b1;
      stop  = 1'b1;
      tick();
      check("t6 start+stop", obs(), ex(0, 0, 1, 0));
      stop = 1'b0;
      go(0, 8'd1, 8'h0F);
      check("t6 restart", obs(), ex(1, 0, 1, 4));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("t6 stop setup", obs(), ex(0, 0, 1, 4));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the dwell-length input and internal dwell counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a scan; sampled only in IDLE.
REQ-005 stop  input  1  abort request; sampled in every state.
REQ-006 cont  input  1  1 = continuous scan, 0 = single sweep; latched at accepted start.
REQ-007 dwell  input  DWELL_W  cycles each channel stays enabled; latched at accepted start.
REQ-008 skip_mask  input  8  bit n = 1 skips channel n; latched at accepted start.
REQ-009 G  output  1  active-low enable to the downstream 3-to-8 decoder.
REQ-010 A, B, C  output  1 each  decoder select, channel = {C,B,A}.
REQ-011 busy  output  1  high from the cycle after accepted start until return to IDLE.
REQ-012 done  output  1  one-cycle pulse at single-sweep completion.

Function
REQ-013 States SHALL be IDLE, SETUP, ACTIVE, GAP, DONE.
REQ-014 IDLE: G=1, {C,B,A} held, busy=0; start=1 and stop=0 -> latch cont/dwell/skip_mask, go to SETUP.
REQ-015 SETUP: G=1 for exactly 1 cycle; {C,B,A} = lowest-numbered unskipped channel; then ACTIVE.
REQ-016 ACTIVE: G=0, {C,B,A} stable; lasts max(dwell,1) cycles (dwell=0 treated as 1).
REQ-017 End of ACTIVE with further unskipped channel at higher index -> GAP, {C,B,A} = next higher unskipped channel.
REQ-018 End of ACTIVE on highest unskipped channel: cont=1 -> GAP with {C,B,A} = lowest unskipped channel (wrap 7->0); cont=0 -> DONE.
REQ-019 GAP: G=1 for exactly 1 cycle (break-before-make), then ACTIVE.
REQ-020 Address SHALL change only in cycles where G=1; G=0 never coincides with an address transition.
REQ-021 DONE: G=1, done=1 for 1 cycle, then IDLE; busy=0 from IDLE onward.
REQ-022 skip_mask=8'hFF at start: SETUP -> DONE directly; G never asserted low.
REQ-023 stop=1 in SETUP/ACTIVE/GAP/DONE -> next state IDLE, G=1 next cycle, no done pulse.
REQ-024 start and stop both 1 in IDLE: stop wins, remain IDLE.
REQ-025 start while not IDLE SHALL be ignored; input changes to cont/dwell/skip_mask mid-scan have no effect.
REQ-026 Dwell counter SHALL be DWELL_W bits, counting down; no wrap or overflow possible.

Reset
REQ-027 rst=1 asynchronously forces: state IDLE, G=1, {C,B,A}=3'b000, busy=0, done=0, dwell counter 0, latched registers 0.
REQ-028 rst asserted mid-ACTIVE SHALL drive G=1 without waiting for a clock edge.
REQ-029 After rst release, first start is accepted on the first rising edge with rst=0.

Structure
REQ-030 Shared package SHALL hold the state encoding (5 states), constant G_OFF=1'b1, and the default DWELL_W.
REQ-031 One sub-module: scan_next_sel (combinational) -- given current channel and skip_mask, returns next higher unskipped channel, lowest unskipped channel, and a wrap flag.
REQ-032 Outputs G, A, B, C, busy, done SHALL be registered.

Verification
REQ-033 dwell=3, skip_mask=0, cont=0, start pulse -> channels 0..7 each G=0 for 3 cycles, 1-cycle G=1 gaps, done pulse once, busy drops.
REQ-034 skip_mask=8'b1010_1010, dwell=2, cont=1 -> channel sequence 0,2,4,6,0,2,... with G=1 gap before each; no done.
REQ-035 cont=1 running, stop=1 on 2nd ACTIVE cycle of channel 5 -> G=1 next cycle, IDLE, no done.
REQ-036 skip_mask=8'hFF, start -> busy high 2 cycles, done pulse, G stays 1.
REQ-037 dwell=0, skip_mask=8'b1111_1110 -> channel 0 G=0 for exactly 1 cycle, then done.
REQ-038 rst asserted between edges during ACTIVE -> G=1, outputs at reset values immediately; start+stop together afterward -> remains IDLE.
